// File: rtl/tinst_pkg.sv
// Shared tile-instruction types for the tile dispatch path.
// Type codes, field widths and the queued instruction entry.
package tinst_pkg;

   localparam int TINST_TYPE_WIDTH     = 2;
   localparam int ADDR_WIDTH           = 64;
   localparam int TMMA_PRECISION_WIDTH = 3;

   typedef enum logic [TINST_TYPE_WIDTH-1:0] {
      TMMA     = 2'd0,
      PRELOADA = 2'd1,
      PRELOADC = 2'd2,
      STOREC   = 2'd3
   } tinst_type_e;

   typedef struct packed {
      tinst_type_e                     typ;
      logic [ADDR_WIDTH-1:0]           addr0;
      logic [ADDR_WIDTH-1:0]           addr1;
      logic [TMMA_PRECISION_WIDTH-1:0] precision;
      logic                            acc;
   } tinst_t;

   // C-buffer instructions act as a full fence around the array
   function automatic logic is_fence(tinst_type_e t);
      return (t == PRELOADC) || (t == STOREC);
   endfunction

endpackage

// File: rtl/tinst_fifo.sv
// In-order instruction FIFO with combinational head read.
// Pointers wrap naturally because DEPTH is a power of two.
module tinst_fifo
   import tinst_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  tinst_t                 din,
   output tinst_t                 head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   tinst_t         mem [DEPTH];
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;

   assign head  = mem[rptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   // storage, pointers and occupancy count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push && !full) begin
            mem[wptr] <= din;
            wptr      <= wptr + 1'b1;
         end
         if (pop && !empty) rptr <= rptr + 1'b1;
         unique case ({push && !full, pop && !empty})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tinst_dispatch.sv
// Tile-instruction scheduler: queues decoded instructions and issues
// them in order once A-buffer and fence hazards allow.
module tinst_dispatch
   import tinst_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int MAX_OUTS = 2,
   parameter int A_SLOTS  = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            dec_valid_i,
   output logic                            dec_ready_o,
   input  logic [TINST_TYPE_WIDTH-1:0]     dec_type_i,
   input  logic [ADDR_WIDTH-1:0]           dec_addr0_i,
   input  logic [ADDR_WIDTH-1:0]           dec_addr1_i,
   input  logic [TMMA_PRECISION_WIDTH-1:0] dec_precision_i,
   input  logic                            dec_acc_i,
   output logic                            iss_valid_o,
   input  logic                            iss_ready_i,
   output logic [TINST_TYPE_WIDTH-1:0]     iss_type_o,
   output logic [ADDR_WIDTH-1:0]           iss_addr0_o,
   output logic [ADDR_WIDTH-1:0]           iss_addr1_o,
   output logic [TMMA_PRECISION_WIDTH-1:0] iss_precision_o,
   output logic                            iss_acc_o,
   input  logic                            done_valid_i,
   input  logic [TINST_TYPE_WIDTH-1:0]     done_type_i,
   output logic                            busy_o,
   output logic                            stall_o,
   output logic                            err_o
);

   localparam int OW = $clog2(MAX_OUTS+1);
   localparam int CW = $clog2(DEPTH)+1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      SEND  = 2'd2
   } state_e;

   state_e          state;
   state_e          state_nx;
   tinst_t          din;
   tinst_t          head;
   logic            full;
   logic            empty;
   logic [CW-1:0]   count;
   logic            push;
   logic            pop;
   logic            hz_ok;
   logic [OW-1:0]   outs_cnt;
   logic [OW-1:0]   outs_nx;
   logic [1:0]      a_loaded;
   logic [1:0]      a_pend;
   logic [1:0]      ald_nx;
   logic [1:0]      pend_nx;
   logic            fence_r;
   logic            err_r;
   logic            done_pa;
   logic            done_tm;
   logic            done_fn;
   logic            pa_ok;
   logic            tm_ok;
   logic            iss_pa;
   logic            iss_fn;
   logic            err_set;

   assign din = '{typ:       tinst_type_e'(dec_type_i),
                  addr0:     dec_addr0_i,
                  addr1:     dec_addr1_i,
                  precision: dec_precision_i,
                  acc:       dec_acc_i};

   assign push = dec_valid_i && dec_ready_o;
   assign pop  = iss_valid_o && iss_ready_i;

   tinst_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign dec_ready_o     = !full;
   assign iss_valid_o     = (state == SEND);
   assign iss_type_o      = head.typ;
   assign iss_addr0_o     = head.addr0;
   assign iss_addr1_o     = head.addr1;
   assign iss_precision_o = head.precision;
   assign iss_acc_o       = head.acc;
   assign stall_o         = (state == CHECK) && !hz_ok;
   assign busy_o          = !empty || (outs_cnt != '0);
   assign err_o           = err_r;

   // hazard check for the head entry
   always_comb begin
      hz_ok = (outs_cnt < OW'(MAX_OUTS)) && !fence_r;
      unique case (head.typ)
         PRELOADA: if (({1'b0, a_loaded} + {1'b0, a_pend}) >= 3'(A_SLOTS)) hz_ok = 1'b0;
         TMMA:     if (a_loaded == '0) hz_ok = 1'b0;
         PRELOADC,
         STOREC:   if (outs_cnt != '0) hz_ok = 1'b0;
      endcase
   end

   // issue state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // issue next-state: wait for an entry, clear hazards, hold until taken
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (count != '0) state_nx = CHECK;
         CHECK:   if (hz_ok) state_nx = SEND;
         SEND:    if (iss_ready_i)
                     state_nx = ((count > CW'(1)) || push) ? CHECK : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // completion decode and saturating counter updates
   always_comb begin
      done_pa = done_valid_i && (done_type_i == PRELOADA);
      done_tm = done_valid_i && (done_type_i == TMMA);
      done_fn = done_valid_i && is_fence(tinst_type_e'(done_type_i));
      iss_pa  = pop && (head.typ == PRELOADA);
      iss_fn  = pop && is_fence(head.typ);
      pa_ok   = done_pa && (a_pend != '0);
      tm_ok   = done_tm && (a_loaded != '0);
      outs_nx = outs_cnt;
      if (pop && !done_valid_i)
         outs_nx = outs_cnt + OW'(1);
      else if (!pop && done_valid_i && (outs_cnt != '0))
         outs_nx = outs_cnt - OW'(1);
      pend_nx = a_pend + 2'(iss_pa) - 2'(pa_ok);
      ald_nx  = a_loaded + 2'(pa_ok) - 2'(tm_ok);
      err_set = (done_valid_i && (outs_cnt == '0) && !pop)
              || (done_tm && (a_loaded == '0))
              || (done_pa && (a_pend == '0));
   end

   // hazard tracking state and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outs_cnt <= '0;
         a_pend   <= '0;
         a_loaded <= '0;
         fence_r  <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         outs_cnt <= outs_nx;
         a_pend   <= pend_nx;
         a_loaded <= ald_nx;
         if (iss_fn)       fence_r <= 1'b1;
         else if (done_fn) fence_r <= 1'b0;
         if (err_set) err_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tinst_dispatch.sv
// Directed hazard scenarios plus a random program run against
// a queue-based model of the dispatcher and the array.
module tb_tinst_dispatch;
   import tinst_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dec_valid;
   logic        dec_ready;
   logic [1:0]  dec_type;
   logic [63:0] dec_addr0;
   logic [63:0] dec_addr1;
   logic [2:0]  dec_precision;
   logic        dec_acc;
   logic        iss_valid;
   logic        iss_ready;
   logic [1:0]  iss_type;
   logic [63:0] iss_addr0;
   logic [63:0] iss_addr1;
   logic [2:0]  iss_precision;
   logic        iss_acc;
   logic        done_valid;
   logic [1:0]  done_type;
   logic        busy;
   logic        stall;
   logic        err;

   int n_assert = 0;
   int n_fail   = 0;

   tinst_t      pend_q[$];
   tinst_type_e out_q[$];
   int          ald;

   always #5 clk = ~clk;

   tinst_dispatch dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .dec_valid_i     (dec_valid),
      .dec_ready_o     (dec_ready),
      .dec_type_i      (dec_type),
      .dec_addr0_i     (dec_addr0),
      .dec_addr1_i     (dec_addr1),
      .dec_precision_i (dec_precision),
      .dec_acc_i       (dec_acc),
      .iss_valid_o     (iss_valid),
      .iss_ready_i     (iss_ready),
      .iss_type_o      (iss_type),
      .iss_addr0_o     (iss_addr0),
      .iss_addr1_o     (iss_addr1),
      .iss_precision_o (iss_precision),
      .iss_acc_o       (iss_acc),
      .done_valid_i    (done_valid),
      .done_type_i     (done_type),
      .busy_o          (busy),
      .stall_o         (stall),
      .err_o           (err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input tinst_type_e t, input logic [63:0] a0);
      dec_valid     = 1'b1;
      dec_type      = t;
      dec_addr0     = a0;
      dec_addr1     = ~a0;
      dec_precision = a0[2:0];
      dec_acc       = a0[0];
      @(negedge clk);
      dec_valid     = 1'b0;
   endtask

   task automatic done(input tinst_type_e t);
      done_valid = 1'b1;
      done_type  = t;
      @(negedge clk);
      done_valid = 1'b0;
   endtask

   task automatic wait_issue(input string tag, input tinst_type_e t, input logic [63:0] a0);
      int n = 0;
      while (iss_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_vld"}, 64'(iss_valid), 64'd1);
      chk({tag, "_type"}, 64'(iss_type), 64'(t));
      chk({tag, "_addr"}, iss_addr0, a0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      dec_valid  = 1'b0;
      done_valid = 1'b0;
      @(negedge clk);
      rst_n      = 1'b1;
      iss_ready  = 1'b1;
      @(negedge clk);
   endtask

   // hazard rules applied to model state; TMMA rule optional because
   // an older TMMA completing during SEND may legally drop the A count
   function automatic bit model_clear(tinst_type_e t, bit tmma_rule);
      int  outs  = out_q.size();
      int  pend  = 0;
      bit  fence = 1'b0;
      bit  ok;
      foreach (out_q[i]) begin
         if (out_q[i] == PRELOADA) pend++;
         if (out_q[i] == PRELOADC || out_q[i] == STOREC) fence = 1'b1;
      end
      ok = (outs < 2) && !fence;
      case (t)
         PRELOADA: if (ald + pend >= 2) ok = 1'b0;
         TMMA:     if (tmma_rule && ald < 1) ok = 1'b0;
         default:  if (outs != 0) ok = 1'b0;
      endcase
      return ok;
   endfunction

   initial begin
      logic [63:0] a;
      int          n;
      int          gen_left;
      int          avail;
      int          cycles;
      tinst_t      e;
      tinst_t      h;
      tinst_type_e t;
      bit          do_push;

      rst_n      = 1'b1;
      dec_valid  = 1'b0;
      dec_type   = '0;
      dec_addr0  = '0;
      dec_addr1  = '0;
      dec_precision = '0;
      dec_acc    = 1'b0;
      iss_ready  = 1'b1;
      done_valid = 1'b0;
      done_type  = '0;
      #2 rst_n = 1'b0;
      cyc(2);
      chk("rst_ready", 64'(dec_ready), 64'd1);
      chk("rst_valid", 64'(iss_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_addr", iss_addr0, 64'd0);
      rst_n = 1'b1;
      cyc(1);

      // TMMA with no A loaded never issues
      push(TMMA, 64'h10);
      cyc(5);
      chk("s1_stall", 64'(stall), 64'd1);
      chk("s1_novalid", 64'(iss_valid), 64'd0);
      chk("s1_busy", 64'(busy), 64'd1);
      do_reset();

      push(PRELOADA, 64'h100);
      wait_issue("s1_pa", PRELOADA, 64'h100);
      push(TMMA, 64'h200);
      cyc(3);
      chk("s1_tm_stall", 64'(stall), 64'd1);
      done(PRELOADA);
      chk("s1_chk_stall", 64'(stall), 64'd0);
      chk("s1_chk_valid", 64'(iss_valid), 64'd0);
      @(negedge clk);
      chk("s1_tm_send", 64'(iss_valid), 64'd1);
      wait_issue("s1_tm", TMMA, 64'h200);
      done(TMMA);
      chk("s1_idle_busy", 64'(busy), 64'd0);
      chk("s1_err", 64'(err), 64'd0);
      push(TMMA, 64'h300);
      cyc(3);
      chk("s1_aload0", 64'(stall), 64'd1);
      do_reset();

      // double buffer: third PRELOADA waits for a TMMA completion
      push(PRELOADA, 64'h1);
      push(PRELOADA, 64'h2);
      push(PRELOADA, 64'h3);
      wait_issue("s2_pa1", PRELOADA, 64'h1);
      wait_issue("s2_pa2", PRELOADA, 64'h2);
      cyc(4);
      chk("s2_pa3_stall", 64'(stall), 64'd1);
      chk("s2_pa3_novld", 64'(iss_valid), 64'd0);
      done(PRELOADA);
      cyc(3);
      chk("s2_still", 64'(stall), 64'd1);
      done(TMMA);
      wait_issue("s2_pa3", PRELOADA, 64'h3);
      chk("s2_err", 64'(err), 64'd0);
      do_reset();

      // PRELOADC fence in both directions
      push(PRELOADA, 64'h10);
      wait_issue("s3_pa1", PRELOADA, 64'h10);
      push(PRELOADA, 64'h11);
      wait_issue("s3_pa2", PRELOADA, 64'h11);
      done(PRELOADA);
      done(PRELOADA);
      push(TMMA, 64'h20);
      wait_issue("s3_t1", TMMA, 64'h20);
      push(PRELOADC, 64'h30);
      cyc(3);
      chk("s3_pc_stall", 64'(stall), 64'd1);
      done(TMMA);
      wait_issue("s3_pc", PRELOADC, 64'h30);
      push(TMMA, 64'h21);
      cyc(4);
      chk("s3_t2_stall", 64'(stall), 64'd1);
      done(PRELOADC);
      wait_issue("s3_t2", TMMA, 64'h21);
      done(TMMA);
      chk("s3_busy", 64'(busy), 64'd0);
      chk("s3_err", 64'(err), 64'd0);

      // back-pressure holds the issue fields
      a = 64'hABCD;
      iss_ready = 1'b0;
      push(STOREC, a);
      n = 0;
      while (iss_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("s4_hold_vld", 64'(iss_valid), 64'd1);
         chk("s4_hold_type", 64'(iss_type), 64'(STOREC));
         chk("s4_hold_a0", iss_addr0, a);
         chk("s4_hold_a1", iss_addr1, ~a);
         chk("s4_hold_prec", 64'(iss_precision), 64'(a[2:0]));
         chk("s4_hold_acc", 64'(iss_acc), 64'(a[0]));
         @(negedge clk);
      end
      iss_ready = 1'b1;
      @(negedge clk);
      chk("s4_popped", 64'(iss_valid), 64'd0);
      chk("s4_outs_busy", 64'(busy), 64'd1);
      cyc(2);
      chk("s4_one_pop", 64'(iss_valid), 64'd0);
      done(STOREC);
      chk("s4_idle", 64'(busy), 64'd0);

      // FIFO full: fifth instruction refused
      iss_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(STOREC, 64'(i));
      chk("s5_full", 64'(dec_ready), 64'd0);
      push(STOREC, 64'h55);
      chk("s5_full2", 64'(dec_ready), 64'd0);
      chk("s5_head", iss_addr0, 64'd0);
      iss_ready = 1'b1;
      @(negedge clk);
      chk("s5_ready", 64'(dec_ready), 64'd1);
      done(STOREC);
      for (int i = 1; i < 4; i++) begin
         wait_issue("s5_e", STOREC, 64'(i));
         done(STOREC);
      end
      cyc(3);
      chk("s5_no5_vld", 64'(iss_valid), 64'd0);
      chk("s5_no5_busy", 64'(busy), 64'd0);

      // spurious completion, then async reset mid-SEND
      chk("s6_err0", 64'(err), 64'd0);
      done(STOREC);
      chk("s6_err1", 64'(err), 64'd1);
      chk("s6_busy", 64'(busy), 64'd0);
      cyc(3);
      chk("s6_sticky", 64'(err), 64'd1);
      iss_ready = 1'b0;
      push(PRELOADA, 64'h77);
      n = 0;
      while (iss_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("s6_send", 64'(iss_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("s6_rst_vld", 64'(iss_valid), 64'd0);
      chk("s6_rst_busy", 64'(busy), 64'd0);
      chk("s6_rst_err", 64'(err), 64'd0);
      chk("s6_rst_rdy", 64'(dec_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // random legal program against the queue model
      ald      = 0;
      avail    = 0;
      gen_left = 80;
      cycles   = 0;
      while ((gen_left > 0 || pend_q.size() > 0 || out_q.size() > 0) && cycles < 4000) begin
         chk("r_busy", 64'(busy), 64'(pend_q.size() != 0 || out_q.size() != 0));
         chk("r_ready", 64'(dec_ready), 64'(pend_q.size() < 4));
         chk("r_err", 64'(err), 64'd0);
         if (iss_valid === 1'b1) begin
            chk("r_vld_q", 64'(pend_q.size() != 0), 64'd1);
            if (pend_q.size() != 0) begin
               h = pend_q[0];
               chk("r_type", 64'(iss_type), 64'(h.typ));
               chk("r_a0", iss_addr0, h.addr0);
               chk("r_a1", iss_addr1, h.addr1);
               chk("r_prec", 64'(iss_precision), 64'(h.precision));
               chk("r_haz", 64'(model_clear(h.typ, 1'b0)), 64'd1);
            end
         end
         if (stall === 1'b1) begin
            chk("r_stall_q", 64'(pend_q.size() != 0), 64'd1);
            if (pend_q.size() != 0) begin
               h = pend_q[0];
               chk("r_stall_haz", 64'(model_clear(h.typ, 1'b1)), 64'd0);
            end
         end

         do_push = (gen_left > 0) && (dec_ready === 1'b1) && ($urandom_range(0, 1) == 1);
         dec_valid = do_push;
         if (do_push) begin
            t = tinst_type_e'($urandom_range(0, 3));
            if (t == TMMA && avail < 1) t = PRELOADA;
            else if (t == PRELOADA && avail >= 2) t = TMMA;
            if (t == TMMA) avail--;
            if (t == PRELOADA) avail++;
            e.typ       = t;
            e.addr0     = {$urandom, $urandom};
            e.addr1     = {$urandom, $urandom};
            e.precision = 3'($urandom);
            e.acc       = 1'($urandom);
            dec_type      = e.typ;
            dec_addr0     = e.addr0;
            dec_addr1     = e.addr1;
            dec_precision = e.precision;
            dec_acc       = e.acc;
            gen_left--;
         end
         iss_ready  = ($urandom_range(0, 3) != 0);
         done_valid = 1'b0;
         if (out_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            done_valid = 1'b1;
            done_type  = out_q[0];
         end

         if (done_valid) begin
            t = out_q.pop_front();
            if (t == PRELOADA) ald++;
            if (t == TMMA) ald--;
         end
         if (iss_valid === 1'b1 && iss_ready && pend_q.size() > 0) begin
            h = pend_q.pop_front();
            out_q.push_back(h.typ);
         end
         if (do_push) pend_q.push_back(e);
         @(negedge clk);
         cycles++;
      end
      dec_valid  = 1'b0;
      done_valid = 1'b0;
      chk("r_drain", 64'(pend_q.size() + out_q.size()), 64'd0);
      @(negedge clk);
      chk("r_end_busy", 64'(busy), 64'd0);
      chk("r_end_err", 64'(err), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
